// File: rtl/fir_mac_engine.sv
// -----------------------------------------------------------------------------
// fir_mac_engine
//
// Single-multiplier FIR datapath. Each accepted sample strobe writes the sample
// into a circular delay line, then walks all taps one per cycle, multiplying
// x[n-k] by coefficient k fetched from an external registered ROM (one cycle
// read latency). The accumulator is rounded half up, arithmetically shifted
// right by SHIFT and saturated to DATA_W bits to form one output sample.
//
// Ports:
//   clkIn          clock, all logic on the rising edge
//   nResetIn       asynchronous active-low reset
//   sampleValidIn  one-cycle strobe, sample present on sampleIn
//   sampleIn       signed input sample
//   coefAddrOut    registered coefficient ROM address
//   coefIn         signed ROM data, valid one cycle after its address
//   busyOut        high while a computation is in progress
//   resultOut      signed filtered sample, held between updates
//   resultValidOut one-cycle pulse, resultOut updated
//   droppedOut     one-cycle pulse, a strobe arrived while busy
// -----------------------------------------------------------------------------
module fir_mac_engine #(
   parameter int TAPS   = 8,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 40,
   parameter int SHIFT  = 15
) (
   input  logic                     clkIn,
   input  logic                     nResetIn,
   input  logic                     sampleValidIn,
   input  logic signed [DATA_W-1:0] sampleIn,
   output logic [$clog2(TAPS)-1:0]  coefAddrOut,
   input  logic signed [COEF_W-1:0] coefIn,
   output logic                     busyOut,
   output logic signed [DATA_W-1:0] resultOut,
   output logic                     resultValidOut,
   output logic                     droppedOut
);

   localparam int AW = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;
   // One guard bit so adding the rounding bias can never wrap the sum.
   localparam int RW = ACC_W + 1;

   localparam logic signed [RW-1:0] ROUND_BIAS = RW'(1) << (SHIFT - 1);
   localparam logic signed [RW-1:0] SAT_MAX    = (RW'(1) << (DATA_W - 1)) - RW'(1);
   localparam logic signed [RW-1:0] SAT_MIN    = ~SAT_MAX;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_t;

   state_t                    state;
   logic signed [DATA_W-1:0]  delay_line [TAPS];
   logic [AW-1:0]             wr_ptr;
   // Starts at the newest sample and walks backwards: tap k reads x[n-k].
   logic [AW-1:0]             rd_ptr;
   // Counts MAC cycles; cycle 0 only primes the ROM, cycles 1..TAPS accumulate.
   logic [AW:0]               mac_cnt;
   logic signed [ACC_W-1:0]   acc;

   logic signed [PW-1:0]      product;
   logic signed [ACC_W-1:0]   product_ext;
   logic signed [RW-1:0]      rounded;
   logic signed [RW-1:0]      shifted;
   logic signed [DATA_W-1:0]  sat_result;

   // Full-precision signed product, sign-extended into the accumulator width.
   assign product     = PW'(coefIn) * PW'(delay_line[rd_ptr]);
   assign product_ext = ACC_W'(product);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned and infers a latch.
      sat_result = '0;
      rounded    = RW'(acc) + ROUND_BIAS;
      shifted    = rounded >>> SHIFT;
      if (shifted > SAT_MAX) begin
         sat_result = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_result = SAT_MIN[DATA_W-1:0];
      end else begin
         sat_result = shifted[DATA_W-1:0];
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) begin
         state          <= IDLE;
         // NOTE: the delay line is deliberately cleared on reset so the first
         // outputs after reset see zero history instead of stale samples.
         for (int i = 0; i < TAPS; i++) begin
            delay_line[i] <= '0;
         end
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         mac_cnt        <= '0;
         acc            <= '0;
         coefAddrOut    <= '0;
         resultOut      <= '0;
         resultValidOut <= 1'b0;
         busyOut        <= 1'b0;
         droppedOut     <= 1'b0;
      end else begin
         resultValidOut <= 1'b0;
         // Any strobe outside IDLE, including the DONE cycle, is discarded.
         droppedOut     <= sampleValidIn && (state != IDLE);

         case (state)
            IDLE: begin
               if (sampleValidIn) begin
                  delay_line[wr_ptr] <= sampleIn;
                  rd_ptr             <= wr_ptr;
                  wr_ptr             <= wr_ptr + 1'b1;
                  acc                <= '0;
                  mac_cnt            <= '0;
                  coefAddrOut        <= '0;
                  busyOut            <= 1'b1;
                  state              <= MAC;
               end
            end

            MAC: begin
               // Address runs one cycle ahead of the data it selects and then
               // parks on the last tap.
               if (coefAddrOut != AW'(TAPS - 1)) begin
                  coefAddrOut <= coefAddrOut + 1'b1;
               end
               if (mac_cnt != '0) begin
                  acc    <= acc + product_ext;
                  rd_ptr <= rd_ptr - 1'b1;
               end
               if (mac_cnt == (AW + 1)'(TAPS)) begin
                  state <= DONE;
               end
               mac_cnt <= mac_cnt + 1'b1;
            end

            DONE: begin
               resultOut      <= sat_result;
               resultValidOut <= 1'b1;
               busyOut        <= 1'b0;
               state          <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_engine
//
// Self-checking bench for fir_mac_engine. A registered ROM model feeds coefIn.
// Each accepted strobe pushes the golden filter output (computed from the
// bench's own sample history) onto a scoreboard queue; entries are popped when
// the DUT pulses resultValidOut. Busy, drop, address and pulse timing are
// predicted cycle by cycle from the strobe schedule.
// -----------------------------------------------------------------------------
module tb_fir_mac_engine;

   localparam int TAPS   = 8;
   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int ACC_W  = 40;
   localparam int SHIFT  = 15;
   localparam int AW     = $clog2(TAPS);

   logic                     clkIn;
   logic                     nResetIn;
   logic                     sampleValidIn;
   logic signed [DATA_W-1:0] sampleIn;
   logic [AW-1:0]            coefAddrOut;
   logic signed [COEF_W-1:0] coefIn;
   logic                     busyOut;
   logic signed [DATA_W-1:0] resultOut;
   logic                     resultValidOut;
   logic                     droppedOut;

   fir_mac_engine #(
      .TAPS  (TAPS),
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
   ) dut (
      .clkIn         (clkIn),
      .nResetIn      (nResetIn),
      .sampleValidIn (sampleValidIn),
      .sampleIn      (sampleIn),
      .coefAddrOut   (coefAddrOut),
      .coefIn        (coefIn),
      .busyOut       (busyOut),
      .resultOut     (resultOut),
      .resultValidOut(resultValidOut),
      .droppedOut    (droppedOut)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   // Registered coefficient ROM, one cycle read latency.
   logic signed [COEF_W-1:0] coef_rom [TAPS];
   always @(posedge clkIn) coefIn <= coef_rom[coefAddrOut];

   // Bench-side reference state.
   logic signed [DATA_W-1:0] hist [TAPS];   // hist[k] = x[n-k]
   logic signed [DATA_W-1:0] exp_q [$];
   logic signed [DATA_W-1:0] exp_result;
   int                       busy_cnt;
   int                       valid_cnt;
   int                       exp_addr;
   logic                     exp_drop;
   int                       stim [$];

   int n_compared;
   int n_mismatched;

   task automatic check(input string tag, input longint got, input longint exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic signed [DATA_W-1:0] golden();
      longint acc;
      longint r;
      longint hi;
      longint lo;
      acc = 0;
      for (int k = 0; k < TAPS; k++) begin
         acc += longint'(coef_rom[k]) * longint'(hist[k]);
      end
      acc = (acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
      r   = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      hi  = (longint'(1) <<< (DATA_W - 1)) - 1;
      lo  = -hi - 1;
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
      return DATA_W'(r);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) hist[k] = '0;
      exp_q.delete();
      exp_result = '0;
      busy_cnt   = 0;
      valid_cnt  = 0;
      exp_addr   = 0;
      exp_drop   = 1'b0;
   endtask

   // One clock cycle: check the outputs produced by the previous edge, then
   // drive this cycle's inputs and advance the reference model.
   task automatic step(input logic strb, input logic signed [DATA_W-1:0] smp);
      logic exp_busy;
      logic exp_valid;
      @(negedge clkIn);
      exp_valid = 1'b0;
      if (valid_cnt > 0) begin
         valid_cnt--;
         exp_valid = (valid_cnt == 0);
      end
      exp_busy = (busy_cnt > 0);
      if (exp_busy) begin
         exp_addr = (TAPS + 2 - busy_cnt > TAPS - 1) ? TAPS - 1 : TAPS + 2 - busy_cnt;
         busy_cnt--;
      end
      check("busy", busyOut, exp_busy);
      check("dropped", droppedOut, exp_drop);
      check("coef_addr", coefAddrOut, exp_addr);
      check("result_valid", resultValidOut, exp_valid);
      if (resultValidOut && exp_q.size() != 0) begin
         exp_result = exp_q.pop_front();
      end
      check("result", resultOut, exp_result);

      sampleValidIn = strb;
      sampleIn      = smp;
      exp_drop      = strb && exp_busy;
      if (strb && !exp_busy) begin
         for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = smp;
         exp_q.push_back(golden());
         busy_cnt  = TAPS + 2;
         valid_cnt = TAPS + 3;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   // Play every sample queued in stim, one strobe per 'spacing' cycles.
   task automatic play(input int spacing);
      foreach (stim[i]) begin
         step(1'b1, DATA_W'(stim[i]));
         idle(spacing - 1);
      end
      stim.delete();
   endtask

   task automatic set_ramp_coefs();
      for (int k = 0; k < TAPS; k++) coef_rom[k] = COEF_W'(4096 * (k + 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_compared    = 0;
      n_mismatched  = 0;
      nResetIn      = 1'b0;
      sampleValidIn = 1'b0;
      sampleIn      = '0;
      set_ramp_coefs();
      model_clear();

      // Reset state.
      repeat (2) @(negedge clkIn);
      check("rst_busy", busyOut, 0);
      check("rst_valid", resultValidOut, 0);
      check("rst_result", resultOut, 0);
      check("rst_addr", coefAddrOut, 0);
      check("rst_dropped", droppedOut, 0);
      nResetIn = 1'b1;

      // Impulse response, strobes every 12 cycles.
      stim = '{8192, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      play(12);
      idle(4);

      // Positive then negative saturation with full-scale coefficients.
      for (int k = 0; k < TAPS; k++) coef_rom[k] = 16'sd32767;
      for (int i = 0; i < TAPS; i++) stim.push_back(32767);
      play(12);
      for (int i = 0; i < TAPS; i++) stim.push_back(-32768);
      play(12);

      // Rounding at exactly one half LSB.
      for (int k = 0; k < TAPS; k++) coef_rom[k] = '0;
      coef_rom[0] = 16'sd1;
      stim = '{16384, -16384, 16385, -16385};
      play(12);

      // Drop: second strobe at T+3, another in the DONE cycle T+10.
      set_ramp_coefs();
      step(1'b1, 16'sd1000);
      idle(2);
      step(1'b1, 16'sd5000);
      idle(6);
      step(1'b1, 16'sd7000);
      idle(1);
      stim = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      play(12);

      // Back-to-back strobes coinciding with resultValidOut, ramp 1..20.
      for (int i = 1; i <= 20; i++) stim.push_back(i);
      play(TAPS + 3);
      idle(4);

      // Reset in the middle of a MAC phase, then a fresh impulse.
      step(1'b1, 16'sd8192);
      idle(4);
      @(negedge clkIn);
      nResetIn      = 1'b0;
      sampleValidIn = 1'b0;
      #1;
      check("midrst_busy", busyOut, 0);
      check("midrst_valid", resultValidOut, 0);
      check("midrst_result", resultOut, 0);
      model_clear();
      repeat (2) @(negedge clkIn);
      nResetIn = 1'b1;
      stim = '{8192, 0, 0, 0, 0, 0, 0, 0, 0};
      play(12);
      idle(4);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
